lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit of the RV32I 5-stage pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the address (ALUResultM), store data and access type, and runs a req/ready handshake to a multi-cycle data memory.
- Stalls the pipeline until the access completes.
- Delivers aligned, sign- or zero-extended load data on DMRd for the MEM/WB register.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, cycles in WAIT before a bus error is raised (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MemReadM  in  1  load in MEM stage.
- MemWriteM  in  1  store in MEM stage.
- Funct3M  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ALUResultM  in  DATA_WIDTH  byte address.
- WriteDataM  in  DATA_WIDTH  store data, right-justified.
- FlushM  in  1  kill the MEM-stage instruction.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_WIDTH  word address, ALUResultM with [1:0] forced to 00.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  slave completion, sampled only in WAIT.
- mem_rdata  in  DATA_WIDTH  read word, valid with mem_ready.
- DMRd  out  DATA_WIDTH  extended load data, to MEM/WB.
- StallM  out  1  combinational stall request to the hazard unit.
- MisalignM  out  1  one-cycle misaligned/illegal-access flag.

Behaviour:
- Reset: state IDLE. mem_req, mem_we, mem_addr, mem_wdata, mem_be, DMRd and MisalignM all register 0. StallM is forced to 0 while rst is high.
- Access: access = (MemReadM | MemWriteM) & ~FlushM. If MemWriteM and MemReadM are both set, the write wins and the read is ignored.
- Misalignment/illegal check:
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
  - Illegal: Funct3M of 011, 110 or 111.
  - Either case: no bus request, MisalignM=1 for the next cycle, DMRd=0, StallM=0.
- FSM, IDLE:
  - On an aligned access: StallM=1 combinationally. At the edge, register mem_req=1, mem_we, mem_addr, mem_wdata and mem_be, then go to WAIT.
  - Otherwise stay in IDLE.
- FSM, WAIT:
  - StallM=1. mem_req and the bus fields are held stable.
  - On an edge with mem_ready=1: mem_req←0, DMRd←extended mem_rdata (loads) or 0 (stores), go to DONE.
- FSM, DONE:
  - StallM=0 for exactly one cycle so the pipeline advances and MEM/WB captures DMRd.
  - Next state is IDLE. A new access is not evaluated in DONE.
- Latency: with mem_ready on the first WAIT cycle, StallM is high for 2 cycles (IDLE-detect and WAIT), and DMRd is valid in DONE.
- Store lanes:
  - SB: wdata = byte replicated 4×, be = 0001 << addr[1:0].
  - SH: wdata = halfword replicated 2×, be = 0011 << addr[1:0].
  - SW: wdata unchanged, be = 1111.
- Load extract: lane selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- Flush:
  - FlushM in IDLE suppresses the access.
  - FlushM during WAIT is latched. The bus transaction still completes (no abort), then DMRd=0.
- Reset mid-WAIT: mem_req drops at the next edge and the state returns to IDLE. The slave must tolerate an abandoned request.
- DMRd holds its last value in IDLE until overwritten.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ready: mem_req←0, DMRd←0, MisalignM pulses 1 (reused as the bus-error flag), state goes to DONE.
- Undefined: no counter; WAIT persists indefinitely until mem_ready.

Decomposition:
- Package lsu_pkg:
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {IDLE, WAIT, DONE}.
  - DATA_WIDTH default constant.
- Sub-module lsu_align: purely combinational store-lane replication, byte-enable generation, load extraction and extension, and misalign/illegal detection. lsu_mem_stage holds the FSM, registers and timeout.

Test Plan:
- LW addr 0x100, mem_ready at first WAIT, rdata 0xDEADBEEF → mem_req=1, mem_addr=0x100, be=1111; StallM high 2 cycles; DMRd=0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80112233 → DMRd=0xFFFFFF80. LBU same → DMRd=0x00000080. LHU addr 0x102 → DMRd=0x00008011.
- SH addr 0x206, WriteDataM 0x1234ABCD → mem_we=1, mem_wdata=0xABCDABCD, mem_be=1100, mem_addr=0x204; ready after 3 wait cycles → StallM high 4 cycles.
- LW addr 0x101 → no mem_req, MisalignM=1 one cycle, StallM=0, DMRd=0. Funct3 011 → same response.
- Load with FlushM asserted in WAIT, ready with rdata 0xCAFEBABE → transaction completes, DMRd=0. Separately, rst during WAIT → mem_req=0 and state IDLE at the next edge.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0 → after 4 WAIT cycles mem_req=0, MisalignM=1, StallM released in DONE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access-size codes,
// FSM state encoding and the default data width.
package lsu_pkg;

   localparam int XLEN           = 32;
   localparam int LSU_DATA_WIDTH = XLEN;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and byte enables, alignment and
// illegal-size detection, and load lane extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] store_data,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_offset,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] lane_wdata,
   output logic [3:0]      lane_be,
   output logic            bad_access,
   output logic [XLEN-1:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      lane_wdata = store_data;
      lane_be    = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            lane_wdata = {4{store_data[7:0]}};
            lane_be    = 4'b0001 << offset;
         end
         2'b01: begin
            lane_wdata = {2{store_data[15:0]}};
            lane_be    = 4'b0011 << offset;
         end
         default: ;
      endcase
   end

   always_comb begin
      bad_access = 1'b0;
      case (funct3)
         F3_B, F3_BU: bad_access = 1'b0;
         F3_H, F3_HU: bad_access = offset[0];
         F3_W:        bad_access = |offset;
         default:     bad_access = 1'b1;
      endcase
   end

   // Load lanes come from the offset captured when the request was issued.
   assign ld_byte = rdata[{ld_offset, 3'b000} +: 8];
   assign ld_half = rdata[{ld_offset[1], 4'b0000} +: 16];

   always_comb begin
      ld_data = '0;
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_W:    ld_data = rdata;
         F3_BU:   ld_data = {24'd0, ld_byte};
         F3_HU:   ld_data = {16'd0, ld_half};
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I memory-stage LSU: req/ready handshake to a multi-cycle data memory with
// pipeline stall. Optional WAIT timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = LSU_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            Funct3M,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic                  FlushM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] DMRd,
   output logic                  StallM,
   output logic                  MisalignM
);

   if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("lsu_mem_stage: DATA_WIDTH must be 32 and TIMEOUT_CYCLES at least 1");
   end

   lsu_state_t            state, next_state;
   logic                  access, start, fault, complete, timeout, bad_access;
   logic [DATA_WIDTH-1:0] lane_wdata, ld_data;
   logic [3:0]            lane_be;
   logic [2:0]            ld_funct3_q;
   logic [1:0]            ld_offset_q;
   logic                  is_store_q, flushed_q;

   lsu_align u_align (
      .funct3     (Funct3M),
      .offset     (ALUResultM[1:0]),
      .store_data (WriteDataM),
      .ld_funct3  (ld_funct3_q),
      .ld_offset  (ld_offset_q),
      .rdata      (mem_rdata),
      .lane_wdata (lane_wdata),
      .lane_be    (lane_be),
      .bad_access (bad_access),
      .ld_data    (ld_data)
   );

   assign access   = (MemReadM | MemWriteM) & ~FlushM;
   assign start    = (state == IDLE) && access && !bad_access;
   assign fault    = (state == IDLE) && access && bad_access;
   assign complete = (state == WAIT) && mem_ready;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;

   assign timeout = (state == WAIT) && !mem_ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || start)
         wait_cnt <= '0;
      else if (state == WAIT)
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = WAIT;
         WAIT:    if (complete || timeout) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      StallM = !rst && (start || (state == WAIT));
   end

   // Bus fields are captured once at issue and held until the next access.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         DMRd        <= '0;
         MisalignM   <= 1'b0;
         ld_funct3_q <= '0;
         ld_offset_q <= '0;
         is_store_q  <= 1'b0;
         flushed_q   <= 1'b0;
      end else begin
         MisalignM <= fault | timeout;
         if (start) begin
            mem_req     <= 1'b1;
            mem_we      <= MemWriteM;
            mem_addr    <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            mem_wdata   <= lane_wdata;
            mem_be      <= lane_be;
            ld_funct3_q <= Funct3M;
            ld_offset_q <= ALUResultM[1:0];
            is_store_q  <= MemWriteM;
            flushed_q   <= 1'b0;
         end
         if (state == WAIT)
            flushed_q <= flushed_q | FlushM;
         if (complete) begin
            mem_req <= 1'b0;
            DMRd    <= (is_store_q || flushed_q || FlushM) ? '0 : ld_data;
         end else if (timeout) begin
            mem_req <= 1'b0;
            DMRd    <= '0;
         end
         if (fault)
            DMRd <= '0;
      end
   end

endmodule
